// File: rtl/ackfifo_ctrl.sv
// ackfifo_ctrl: 64x32 FIFO controller driving an external two-port RAM (write port C, read port A)
module ackfifo_ctrl #(
  parameter int AFULL_LEVEL  = 48,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WE,
  input  logic [31:0] DATA,
  input  logic        RE,
  output logic [31:0] Q,
  output logic        Q_VALID,
  output logic        FULL,
  output logic        EMPTY,
  output logic        AFULL,
  output logic        AEMPTY,
  output logic [6:0]  COUNT,
  output logic        OVERFLOW,
  output logic        UNDERFLOW,
  output logic [5:0]  C_ADDR,
  output logic [31:0] C_DIN,
  output logic        C_WEN,
  output logic        C_BLK,
  output logic [5:0]  A_ADDR,
  output logic        A_ADDR_EN,
  output logic        A_BLK,
  output logic        A_ADDR_SRST_N,
  input  logic [31:0] A_DOUT
);
  logic [5:0]  wr_ptr, rd_ptr;
  logic [6:0]  count, count_nx;
  logic [31:0] q_hold;
  logic        wr_ok, rd_ok;
  assign wr_ok         = WE & ~FULL & ~RESET;
  assign rd_ok         = RE & ~EMPTY & ~RESET;
  assign C_WEN         = wr_ok;
  assign C_BLK         = wr_ok;
  assign C_ADDR        = wr_ptr;
  assign C_DIN         = DATA;
  assign A_ADDR_EN     = rd_ok;
  assign A_BLK         = rd_ok;
  assign A_ADDR        = rd_ptr;
  assign A_ADDR_SRST_N = ~RESET;
  assign COUNT         = count;
  // RAM output is transparent: live data while valid, last popped word otherwise
  assign Q             = Q_VALID ? A_DOUT : q_hold;
  always_comb
    count_nx = (wr_ok & ~rd_ok) ? count + 7'd1 :
               (rd_ok & ~wr_ok) ? count - 7'd1 : count;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      Q_VALID   <= 1'b0;
      q_hold    <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 6'd1;
      if (rd_ok) rd_ptr <= rd_ptr + 6'd1;
      if (Q_VALID) q_hold <= A_DOUT;
      count     <= count_nx;
      FULL      <= count_nx == 7'd64;
      EMPTY     <= count_nx == 7'd0;
      AFULL     <= count_nx >= 7'(AFULL_LEVEL);
      AEMPTY    <= count_nx <= 7'(AEMPTY_LEVEL);
      Q_VALID   <= rd_ok;
      OVERFLOW  <= WE & ~wr_ok;
      UNDERFLOW <= RE & ~rd_ok;
    end
  end
endmodule

// File: tb/tb_ackfifo_ctrl.sv
// tb_ackfifo_ctrl: randomized + directed bench against a queue-based FIFO model and a RAM model
module tb_ackfifo_ctrl;
  logic        CLK = 0, RESET = 1, WE = 0, RE = 0;
  logic [31:0] DATA = 0, A_DOUT, Q, C_DIN;
  logic        Q_VALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [6:0]  COUNT;
  logic [5:0]  C_ADDR, A_ADDR;
  logic        C_WEN, C_BLK, A_ADDR_EN, A_BLK, A_ADDR_SRST_N;
  int          passed = 0, total = 0;

  ackfifo_ctrl #(.AFULL_LEVEL(48), .AEMPTY_LEVEL(4)) dut (
    .CLK(CLK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE), .Q(Q), .Q_VALID(Q_VALID),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .C_ADDR(C_ADDR), .C_DIN(C_DIN),
    .C_WEN(C_WEN), .C_BLK(C_BLK), .A_ADDR(A_ADDR), .A_ADDR_EN(A_ADDR_EN), .A_BLK(A_BLK),
    .A_ADDR_SRST_N(A_ADDR_SRST_N), .A_DOUT(A_DOUT)
  );

  always #5 CLK = ~CLK;

  // 64x32 RAM: registered read address, transparent output
  logic [31:0] mem [64];
  logic [5:0]  a_reg = 0;
  always @(posedge CLK) begin
    if (C_WEN && C_BLK) mem[C_ADDR] <= C_DIN;
    if (!A_ADDR_SRST_N) a_reg <= 0;
    else if (A_ADDR_EN && A_BLK) a_reg <= A_ADDR;
  end
  assign A_DOUT = mem[a_reg];

  // FIFO model: queue of stored words, expected registered outputs, push/pop totals
  logic [31:0] mq[$];
  logic [31:0] m_q = 0;
  bit          m_qv = 0, m_ovf = 0, m_unf = 0, live = 0;
  int          wr_tot = 0, rd_tot = 0;
  always @(posedge CLK) begin
    if (RESET) begin
      mq.delete();
      m_qv = 0; m_q = 0; m_ovf = 0; m_unf = 0; wr_tot = 0; rd_tot = 0; live = 1;
    end else begin
      bit aw, ar;
      aw = WE && mq.size() < 64;
      ar = RE && mq.size() > 0;
      m_qv = ar;
      if (ar) begin m_q = mq.pop_front(); rd_tot++; end
      if (aw) begin mq.push_back(DATA); wr_tot++; end
      m_ovf = WE && !aw;
      m_unf = RE && !ar;
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  always @(negedge CLK) if (live) begin
    int n;
    bit ew, er;
    n  = mq.size();
    ew = WE && n < 64 && !RESET;
    er = RE && n > 0 && !RESET;
    chk("COUNT", 32'(COUNT), 32'(n));
    chk("FULL", 32'(FULL), 32'(n == 64));
    chk("EMPTY", 32'(EMPTY), 32'(n == 0));
    chk("AFULL", 32'(AFULL), 32'(n >= 48));
    chk("AEMPTY", 32'(AEMPTY), 32'(n <= 4));
    chk("Q_VALID", 32'(Q_VALID), 32'(m_qv));
    chk("Q", Q, m_q);
    chk("OVERFLOW", 32'(OVERFLOW), 32'(m_ovf));
    chk("UNDERFLOW", 32'(UNDERFLOW), 32'(m_unf));
    chk("C_WEN", 32'(C_WEN), 32'(ew));
    chk("C_BLK", 32'(C_BLK), 32'(ew));
    chk("A_ADDR_EN", 32'(A_ADDR_EN), 32'(er));
    chk("A_BLK", 32'(A_BLK), 32'(er));
    chk("A_ADDR_SRST_N", 32'(A_ADDR_SRST_N), 32'(!RESET));
    if (ew) begin
      chk("C_ADDR", 32'(C_ADDR), 32'(wr_tot % 64));
      chk("C_DIN", C_DIN, DATA);
    end
    if (er) chk("A_ADDR", 32'(A_ADDR), 32'(rd_tot % 64));
  end

  // one clock cycle with the given inputs; returns #1 after the edge
  task automatic cyc(bit we, bit re, logic [31:0] d, bit rst);
    WE = we; RE = re; DATA = d; RESET = rst;
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int pw, pr;
    @(posedge CLK); #1;
    cyc(0, 0, 0, 1);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_aempty", 32'(AEMPTY), 1);
    chk("rst_q", Q, 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(1, 0, 32'(i), 0);
      if (i == 47) chk("afull_at_47", 32'(AFULL), 0);
      if (i == 48) chk("afull_at_48", 32'(AFULL), 1);
    end
    chk("full_64", 32'(FULL), 1);
    chk("count_64", 32'(COUNT), 64);
    cyc(1, 0, 32'd65, 0);
    chk("push65_ovf", 32'(OVERFLOW), 1);
    chk("push65_count", 32'(COUNT), 64);
    cyc(0, 0, 0, 0);
    chk("ovf_one_cycle", 32'(OVERFLOW), 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(0, 1, 0, 0);
      chk("pop_q", Q, 32'(i));
      chk("pop_qv", 32'(Q_VALID), 1);
    end
    chk("drained_empty", 32'(EMPTY), 1);
    cyc(0, 1, 0, 0);
    chk("extra_pop_unf", 32'(UNDERFLOW), 1);
    chk("extra_pop_qv", 32'(Q_VALID), 0);
    chk("q_held", Q, 32'h40);
    cyc(1, 1, 32'hA5, 0);
    chk("both_at0_count", 32'(COUNT), 1);
    chk("both_at0_unf", 32'(UNDERFLOW), 1);
    for (int i = 0; i < 63; i++) cyc(1, 0, $urandom, 0);
    cyc(1, 1, 32'h5A, 0);
    chk("both_at64_count", 32'(COUNT), 63);
    chk("both_at64_ovf", 32'(OVERFLOW), 1);
    for (int i = 0; i < 53; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 200; i++) cyc(1, 1, 32'(1000 + i), 0);
    chk("stream_count", 32'(COUNT), 10);
    for (int i = 0; i < 20; i++) cyc(1, 0, $urandom, 0);
    chk("pre_reset_count", 32'(COUNT), 30);
    cyc(0, 1, 0, 1);
    chk("reset_count", 32'(COUNT), 0);
    chk("reset_empty", 32'(EMPTY), 1);
    chk("reset_qv", 32'(Q_VALID), 0);
    cyc(1, 0, 32'h11, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk("reset_kills_qv", 32'(Q_VALID), 0);
    cyc(1, 0, 32'hDEADBEEF, 0);
    cyc(0, 1, 0, 0);
    chk("deadbeef_q", Q, 32'hDEADBEEF);
    chk("deadbeef_qv", 32'(Q_VALID), 1);
    pw = 50; pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom,
          $urandom_range(0, 499) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ackfifo_ctrl.md
ACKFIFO_CTRL -- requirements
Module: ackfifo_ctrl

Interface
REQ-001 SHALL have parameter AFULL_LEVEL, default 48, COUNT threshold at or above which AFULL asserts (legal 1..63).
REQ-002 SHALL have parameter AEMPTY_LEVEL, default 4, COUNT threshold at or below which AEMPTY asserts (legal 0..62).
REQ-003 SHALL have one clock and a synchronous active-high reset: CLK input 1, sole clock, rising edge; RESET input 1, synchronous, active-high.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- WE input 1: push request.
- DATA input 32: push data.
- RE input 1: pop request.
- Q output 32: pop data.
- Q_VALID output 1: Q holds popped word.
- FULL output 1: 64 words stored.
- EMPTY output 1: 0 words stored.
- AFULL output 1: almost full.
- AEMPTY output 1: almost empty.
- COUNT output 7: words stored, 0..64.
- OVERFLOW output 1: rejected push, 1-cycle pulse.
- UNDERFLOW output 1: rejected pop, 1-cycle pulse.
- C_ADDR output 6: RAM write address.
- C_DIN output 32: RAM write data.
- C_WEN output 1: RAM write enable.
- C_BLK output 1: RAM write port select.
- A_ADDR output 6: RAM read address.
- A_ADDR_EN output 1: RAM read address register enable.
- A_BLK output 1: RAM read port select.
- A_ADDR_SRST_N output 1: RAM read address sync reset.
- A_DOUT input 32: RAM read data.

Function
REQ-005 SHALL control a 64x32 two-port RAM (write port C, read port A); registered read address, transparent output, 1-cycle read latency.
REQ-006 SHALL hold 6-bit WR_PTR, 6-bit RD_PTR and 7-bit COUNT; pointers wrap 63->0 modulo 64.
REQ-007 SHALL accept a push (wr_ok) when WE=1 and FULL=0; wr_ok drives C_WEN=1, C_BLK=1, C_ADDR=WR_PTR, C_DIN=DATA combinationally; WR_PTR increments at that edge.
REQ-008 SHALL reject a push when WE=1 and FULL=0 is false, regardless of RE, and pulse OVERFLOW high the next cycle; RAM, WR_PTR and COUNT are unchanged.
REQ-009 SHALL accept a pop (rd_ok) when RE=1 and EMPTY=0; rd_ok drives A_ADDR_EN=1, A_BLK=1, A_ADDR=RD_PTR combinationally; RD_PTR increments at that edge.
REQ-010 SHALL reject a pop when RE=1 and EMPTY=1, even if WE=1 the same cycle, and pulse UNDERFLOW high the next cycle.
REQ-011 SHALL assert Q_VALID exactly one cycle after each rd_ok, for one cycle per accepted pop, with Q=A_DOUT; back-to-back pops yield one word per cycle.
REQ-012 SHALL hold Q at its last popped value when Q_VALID=0.
REQ-013 SHALL update COUNT every edge: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-014 SHALL register the flags from next-state COUNT: FULL=(COUNT==64), EMPTY=(COUNT==0), AFULL=(COUNT>=AFULL_LEVEL), AEMPTY=(COUNT<=AEMPTY_LEVEL).
REQ-015 SHALL accept a simultaneous push and pop at any COUNT in 1..63 and leave COUNT unchanged.
REQ-016 SHALL accept push and pop together at COUNT=64, taking the pop and rejecting the push (OVERFLOW).
REQ-017 SHALL accept push and pop together at COUNT=0, taking the push and rejecting the pop (UNDERFLOW).
REQ-018 SHALL guarantee that read and write addresses never collide in an accepted cycle.
REQ-019 SHALL drive C_WEN, C_BLK, A_ADDR_EN and A_BLK low when not accepting.

Reset
REQ-020 SHALL, on a clock edge with RESET=1, set WR_PTR=0, RD_PTR=0, COUNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, Q=0, Q_VALID=0, OVERFLOW=0, UNDERFLOW=0.
REQ-021 SHALL take priority over WE/RE while RESET=1: no RAM write, C_WEN=0, A_ADDR_EN=0, A_ADDR_SRST_N=~RESET.
REQ-022 SHALL, on reset during a pop, suppress the Q_VALID pulse owed to that pop.
REQ-023 SHALL not clear RAM contents on reset; stale data is unreachable because COUNT=0.

Verification
REQ-024 SHALL cover: after reset, push 0x00000001..0x00000040 (64 words) -> FULL=1, COUNT=64, AFULL=1 from COUNT 48; 65th push -> OVERFLOW pulse, COUNT stays 64.
REQ-025 SHALL cover: from full, pop 64 consecutive cycles -> Q_VALID every cycle, Q=0x1..0x40 in order, then EMPTY=1; extra pop -> UNDERFLOW pulse, Q_VALID=0.
REQ-026 SHALL cover: push/pop 200 words streaming at COUNT=10 -> pointers wrap, COUNT stays 10, data order preserved.
REQ-027 SHALL cover: WE=RE=1 at COUNT=0 -> COUNT=1, UNDERFLOW=1; WE=RE=1 at COUNT=64 -> COUNT=63, OVERFLOW=1.
REQ-028 SHALL cover: RESET asserted with COUNT=30 and RE=1 -> next cycle COUNT=0, EMPTY=1, Q_VALID=0; subsequent push/pop of 0xDEADBEEF returns 0xDEADBEEF.
